fifo_rd_stream: RTL

//  Read-side adapter between a SyncFIFO (rden/rddata/empty, rddata valid 1 clk after rden) and a valid/ready stream sink.

---
 rtl/fifo_rd_stream_pkg.sv | 12 +
 rtl/stream_skid_buf.sv | 72 +++++++
 rtl/fifo_rd_stream.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the SyncFIFO read-side stream adapter (buffer FSM encodings, buffer depth).
// Optional m_last burst marking is enabled by defining FIFO_RD_STREAM_LAST_EN.
package fifo_rd_stream_pkg;

    // Encodings equal the number of buffered words, so the state doubles as the count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam int FRS_BUF_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output buffer for fifo_rd_stream; slot0 always holds the oldest word.
// Handshake: a word leaves when valid_o & pop_i; push_i is only raised when a free slot is guaranteed.
module stream_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       state_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            S_EMPTY: begin
                if (push_i) begin
                    slot0_d = push_data_i;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push_i && pop_i) begin
                    slot0_d = push_data_i;
                end else if (push_i) begin
                    slot1_d = push_data_i;
                    state_d = S_TWO;
                end else if (pop_i) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop_i) begin
                    slot0_d = slot1_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // The read-credit rule upstream must never deliver a word into a full buffer.
    assert property (@(posedge clk) disable iff (srst) !(push_i && state_q == S_TWO));

    assign valid_o = (state_q != S_EMPTY);
    assign data_o  = slot0_q;
    assign state_o = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter from a SyncFIFO (1-clk read latency) to a valid/ready stream with a 2-word prefetch.
// Define FIFO_RD_STREAM_LAST_EN to build the burst counter that drives m_last; otherwise m_last is 0.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             f_empty,
    output logic             f_rden,
    input  logic [WIDTH-1:0] f_rddata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    logic       inflight_q, inflight_d;
    logic [1:0] buf_state;
    logic [1:0] occ;
    logic       pop;

    if (BURST < 1) begin : g_burst_check
        $error("fifo_rd_stream: BURST must be at least 1");
    end

    stream_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk         (clk),
        .srst        (srst),
        .push_i      (inflight_q),
        .push_data_i (f_rddata),
        .pop_i       (pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .state_o     (buf_state)
    );

    assign pop = m_valid & m_ready;
    // Words already owned by this block: buffered ones plus the one the FIFO is returning now.
    assign occ = buf_state + {1'b0, inflight_q};
    assign f_rden = ~f_empty & ((occ < 2'(FRS_BUF_DEPTH)) | ((occ == 2'(FRS_BUF_DEPTH)) & pop));
    assign inflight_d = f_rden;

    always_ff @(posedge clk) begin
        if (srst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int CW = $clog2(BURST + 1);

    logic [CW-1:0] beat_q, beat_d;
    logic          at_end;

    assign at_end = (beat_q == CW'(BURST - 1));

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = at_end ? '0 : beat_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_last = m_valid & at_end;
`else
    assign m_last = 1'b0;
`endif

endmodule
